// File: rtl/seg_7_hex_scan.sv
// seg_7_hex_scan -- multiplexed N-digit hex 7-segment display driver.
//
// Latches a hex value and per-digit decimal points on `load`, then scans the
// digits one at a time, holding each active for SCAN_DIV clocks. Supports
// leading-zero blanking, global blanking and per-bank output polarity.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   load            capture value_in / dp_in this cycle
//   value_in        DIGITS hex nibbles, digit 0 in bits [3:0]
//   dp_in           decimal point per digit
//   lzb_en          leading-zero blanking enable
//   blank           force segments, dp and com inactive
//   a..g, dp        segment and decimal-point pins
//   com             one-hot digit enable pins
//   scan_tick       one-cycle pulse as the active digit index advances
module seg_7_hex_scan #(
  parameter int DIGITS         = 4,
  parameter int SCAN_DIV       = 1000,
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter bit COM_ACTIVE_LOW = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  lzb_en,
  input  logic                  blank,
  output logic                  a,
  output logic                  b,
  output logic                  c,
  output logic                  d,
  output logic                  e,
  output logic                  f,
  output logic                  g,
  output logic                  dp,
  output logic [DIGITS-1:0]     com,
  output logic                  scan_tick
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [4*DIGITS-1:0] value_q;
  logic [DIGITS-1:0]   dpreg_q;
  logic [PW-1:0]       presc_q, presc_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [6:0]          seg_q;
  logic                dp_q;
  logic [DIGITS-1:0]   com_q, com_d;
  logic                tick_q;

  logic                wrap;
  logic [3:0]          nib;
  logic [6:0]          seg_d;
  logic [DIGITS-1:0]   zero_up;   // nibble i and every nibble above it are 0
  logic                lz_blank;

  // Scan timing: prescaler wrap advances the digit index.
  always_comb begin
    wrap    = (presc_q == PW'(SCAN_DIV - 1));
    presc_d = wrap ? '0 : presc_q + 1'b1;
    idx_d   = idx_q;
    if (wrap) idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
    com_d   = DIGITS'(1) << idx_q;
  end

  // Leading-zero detection runs top-down so each digit sees all digits above it.
  always_comb begin
    logic z;
    z       = 1'b1;
    zero_up = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      z          = z & (value_q[4*i +: 4] == 4'h0);
      zero_up[i] = z;
    end
    lz_blank = lzb_en && (idx_q != '0) && zero_up[idx_q];
  end

  // Hex decode, bit order {a,b,c,d,e,f,g}.
  always_comb begin
    nib = value_q[{idx_q, 2'b00} +: 4];
    unique case (nib)
      4'h0: seg_d = 7'b1111110;
      4'h1: seg_d = 7'b0110000;
      4'h2: seg_d = 7'b1101101;
      4'h3: seg_d = 7'b1111001;
      4'h4: seg_d = 7'b0110011;
      4'h5: seg_d = 7'b1011011;
      4'h6: seg_d = 7'b1011111;
      4'h7: seg_d = 7'b1110000;
      4'h8: seg_d = 7'b1111111;
      4'h9: seg_d = 7'b1111011;
      4'hA: seg_d = 7'b1110111;
      4'hB: seg_d = 7'b0011111;
      4'hC: seg_d = 7'b1001110;
      4'hD: seg_d = 7'b0111101;
      4'hE: seg_d = 7'b1001111;
      default: seg_d = 7'b1000111;
    endcase
  end

  // Outputs decode the current index/value registers, so a load or an index
  // change shows up on the pins one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      value_q <= '0;
      dpreg_q <= '0;
      presc_q <= '0;
      idx_q   <= '0;
      seg_q   <= '0;
      dp_q    <= 1'b0;
      com_q   <= '0;
      tick_q  <= 1'b0;
    end else begin
      if (load) begin
        value_q <= value_in;
        dpreg_q <= dp_in;
      end
      presc_q <= presc_d;
      idx_q   <= idx_d;
      tick_q  <= wrap;
      if (blank) begin
        seg_q <= '0;
        dp_q  <= 1'b0;
        com_q <= '0;
      end else begin
        seg_q <= lz_blank ? 7'b0 : seg_d;
        dp_q  <= dpreg_q[idx_q];
        com_q <= com_d;
      end
    end
  end

  // Polarity is applied only at the pins.
  assign {a, b, c, d, e, f, g} = seg_q ^ {7{SEG_ACTIVE_LOW}};
  assign dp        = dp_q ^ SEG_ACTIVE_LOW;
  assign com       = com_q ^ {DIGITS{COM_ACTIVE_LOW}};
  assign scan_tick = tick_q;

endmodule

// File: doc/seg_7_hex_scan.md
Name: seg_7_hex_scan

Overview:
Multiplexed N-digit hexadecimal 7-segment display driver. Successor to the single-digit static hex decoder. Adds:
- Latched display value with load strobe.
- Time-multiplexed digit scanning with a programmable scan rate.
- Per-digit decimal points.
- Leading-zero blanking.
- Global blanking and selectable output polarity.

Sits between datapath/debug registers and the board's common-cathode/anode display bank.

Parameters:
DIGITS, 4, number of hex digits scanned (1..8); com width.
SCAN_DIV, 1000, clock cycles each digit is held active (>=1).
SEG_ACTIVE_LOW, 0, 1 inverts a..g and dp at the pins.
COM_ACTIVE_LOW, 0, 1 inverts com at the pins.

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
load  input  1  capture value_in/dp_in into display registers this cycle
value_in  input  4*DIGITS  hex nibbles; digit 0 = bits [3:0] (rightmost)
dp_in  input  DIGITS  decimal point per digit
lzb_en  input  1  leading-zero blanking enable
blank  input  1  force all segments and com inactive
a,b,c,d,e,f,g  output  1 each  segment drives
dp  output  1  decimal point drive
com  output  DIGITS  one-hot digit enable
scan_tick  output  1  one-cycle pulse when the active digit advances

Behaviour:
- Polarity: all logic below is in active-high terms. SEG_ACTIVE_LOW / COM_ACTIVE_LOW invert at the output stage only.
- Reset (rst=1 at clk edge):
  - value_reg=0, dp_reg=0.
  - Prescaler=0, digit index=0.
  - All segments and dp inactive, com inactive (all zeros logical), scan_tick=0.
  - First lit output appears the cycle after rst deasserts.
- Load:
  - load=1 captures value_in/dp_in at the edge.
  - New value is visible on outputs one cycle later, for whichever digit is then active.
  - Scan timing is not disturbed by load.
  - load during rst is ignored.
- Prescaler:
  - Counts 0..SCAN_DIV-1, then wraps to 0.
  - On wrap, digit index advances (DIGITS-1 wraps to 0) and scan_tick=1 for that one cycle.
  - SCAN_DIV=1: index advances every cycle; scan_tick is held high.
- Outputs are registered (1-cycle latency from index/value_reg):
  - com = one-hot(index).
  - a..g = hex decode of nibble[index].
  - dp = dp_reg[index].
- Hex decode (lit segments):
  - 0 abcdef, 1 bc, 2 abdeg, 3 abcdg, 4 bcfg, 5 acdfg, 6 acdefg, 7 abc
  - 8 abcdefg, 9 abcdfg, A abcefg, b cdefg, C adef, d bcdeg, E adefg, F aefg
- Leading-zero blanking (lzb_en=1):
  - Digit i is blanked (a..g off) when nibble i and all nibbles above it are 0.
  - Digit 0 is never blanked, so value 0 shows "0".
  - com for a blanked digit stays asserted.
  - dp still follows dp_reg.
- blank=1:
  - a..g, dp and com are all inactive on the next registered output.
  - Prescaler and index keep running.
  - Deasserting blank resumes at the current index with no glitch or realignment.
- DIGITS=1: com is constantly 1 (logical); the index never changes.
- Simultaneous load and index advance: the output for the new index uses the newly loaded value one cycle later (register priority: capture, then decode).

Test Plan:
- Reset: rst high 3 cycles then low. During reset com=0000, a..g=0, dp=0. First output cycle: com=0001, digit 0 of value 0 gives a..f=1, g=0.
- Scan (DIGITS=4, SCAN_DIV=4, load 0x1A3F):
  - com sequence 0001,0010,0100,1000,0001, each held exactly 4 cycles.
  - Segments in order: F→aefg, 3→abcdg, A→abcefg, 1→bc.
  - scan_tick pulses once per 4 cycles.
- Leading-zero blanking: load 0x0050 with lzb_en=1.
  - Digits 3 and 2 show no segments.
  - Digit 1 shows 5 (acdfg); digit 0 shows 0 (abcdef).
  - Load 0x0000: only digit 0 lit, showing 0.
- Decimal point and blank: dp_in=0100.
  - dp=1 only while com=0100.
  - Assert blank mid-digit: next cycle all outputs are 0 and the index keeps advancing. Release: the correct digit resumes on schedule.
- Polarity (SEG_ACTIVE_LOW=1, COM_ACTIVE_LOW=1): digit 8 active gives a..g=0000000, com=1110. After reset, all pins are 1.
- Reset mid-scan: assert rst while index=2. Next cycle outputs are inactive. After release, the scan restarts at digit 0 with a full SCAN_DIV period and value_reg=0.
